pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//   Parametrised program-counter unit: one register plus next-PC selection in one posedge-clocked block.
//   Sits between the control unit (sel, stall, resume) and instruction memory (pc).
//   Adds the following over the earlier PC pair:
//     - register-indirect jumps, call/return and a sign-extended branch offset
//     - a stall input
//     - a HALTED state that can be left by a resume pulse
//     - a configurable reset vector
//     - an optional return-address stack
// PARAMETERS
//   ADDR_W       32            PC width in bits; ADDR_W must be at least 28
//   RESET_VECTOR {ADDR_W{1'b0}} value loaded into pc on reset
//   RAS_DEPTH    4             return-address-stack entries, power of two, 2..16; used only with PC_RAS_EN
// PORTS
//   clk          in   1        clock; all state updates on posedge
//   RST          in   1        reset; asynchronous, active-high
//   stall        in   1        1 = hold pc, FSM and RAS this cycle; sel is ignored
//   sel          in   3        0 NEXT, 1 BRANCH, 2 JUMP, 3 HALT, 4 JREG, 5 CALL, 6 RET, 7 reserved (treated as NEXT)
//   immd16       in   16       branch word offset
//   immd26       in   26       jump/call word target
//   reg_target   in   ADDR_W   register jump target (JREG; RET fallback)
//   resume       in   1        pulse: leave HALTED
//   pc           out  ADDR_W   current fetch address
//   pc_plus4     out  ADDR_W   pc + 4, combinational
//   link_addr    out  ADDR_W   pc + 4, registered on every accepted CALL
//   halted       out  1        1 while in HALTED
//   ras_miss     out  1        1-cycle pulse: RET on empty RAS (PC_RAS_EN only)
// BEHAVIOUR
//   Reset (RST=1, any time, including mid-stall or HALTED):
//     pc=RESET_VECTOR, link_addr=0, halted=0, ras_miss=0, FSM=RUN, RAS emptied.
//   FSM RUN, stall=0: pc loads next on the posedge; latency 1 cycle from sel to pc.
//     NEXT   pc+4
//     BRANCH pc+4 + ({{(ADDR_W-18){immd16[15]}},immd16,2'b00})  (signed)
//     JUMP   {pc[ADDR_W-1:28], immd26, 2'b00}  (same region as current pc)
//     JREG   {reg_target[ADDR_W-1:2], 2'b00}  (low 2 bits forced to 0)
//     CALL   as JUMP; link_addr <= pc+4
//     RET    see CONFIGURATION
//     HALT   pc held; FSM -> HALTED
//   All address arithmetic is modulo 2^ADDR_W; 0xFFFFFFFC + 4 wraps to 0 with no flag.
//   FSM HALTED: pc and link_addr held; sel ignored.
//     resume=1 on a posedge -> pc <= pc+4, FSM -> RUN, halted=0 from that edge.
//   stall=1 has priority over resume and sel in both states; nothing changes, including ras_miss=0.
//   halted is registered: it goes high on the edge that accepts HALT.
// CONFIGURATION
//   PC_RAS_EN defined:
//     - CALL pushes pc+4 onto a RAS_DEPTH-entry circular stack.
//     - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
//     - RET on non-empty stack: pc <= top entry, pop.
//     - RET on empty stack: pc <= JREG target, ras_miss=1 for one cycle.
//     - A simultaneous reset clears the stack with no miss.
//   PC_RAS_EN undefined:
//     - No stack storage; RET behaves exactly as JREG.
//     - ras_miss is tied to 0; RAS_DEPTH is unused.
// TESTING
//   1 Reset/seq: RESET_VECTOR=0x100, RST pulse, 3 cycles NEXT -> pc 0x100,0x104,0x108,0x10C.
//   2 Branch: pc=0x200, BRANCH immd16=0xFFFE -> pc=0x1FC.
//     Then BRANCH immd16=0x0003 -> pc=0x20C.
//   3 Jump/JREG/wrap:
//     - pc=0xF0000010, JUMP immd26=0x0000040 -> pc=0xF0000100.
//     - JREG reg_target=0x00001237 -> pc=0x00001234.
//     - pc=0xFFFFFFFC, NEXT -> pc=0.
//   4 Halt/resume/stall:
//     - pc=0x40, HALT -> halted=1 and pc=0x40 for 5 cycles despite sel=NEXT.
//     - resume with stall=1 -> no change.
//     - resume with stall=0 -> pc=0x44, halted=0.
//   5 RAS (PC_RAS_EN, RAS_DEPTH=4):
//     - CALL from 0x10, 0x20, 0x30; three RETs -> pc=0x34, 0x24, 0x14 and link_addr=0x34 after the last CALL.
//     - A 4th RET -> pc=reg_target, ras_miss=1 for exactly one cycle.
//     - Without the macro: same RET -> pc=reg_target, ras_miss=0.
//   6 Overflow/reset: 5 CALLs with RAS_DEPTH=4 -> 4 RETs return the newest 4 links, the 5th misses.
//     Assert RST between CALL and RET -> pc=RESET_VECTOR, the next RET misses.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter register with next-PC selection, HALTED state,
// stall, configurable reset vector and call/return link handling.
// Optional build macro PC_RAS_EN adds a circular return-address stack with
// RAS_DEPTH entries. Without it, RET behaves as JREG and ras_miss is tied low.
module pc_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              stall,
    input  logic [2:0]        sel,
    input  logic [15:0]       immd16,
    input  logic [25:0]       immd26,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] link_addr,
    output logic              halted,
    output logic              ras_miss
);

    localparam logic [2:0] SEL_NEXT   = 3'd0;
    localparam logic [2:0] SEL_BRANCH = 3'd1;
    localparam logic [2:0] SEL_JUMP   = 3'd2;
    localparam logic [2:0] SEL_HALT   = 3'd3;
    localparam logic [2:0] SEL_JREG   = 3'd4;
    localparam logic [2:0] SEL_CALL   = 3'd5;
    localparam logic [2:0] SEL_RET    = 3'd6;

    typedef enum logic {S_RUN, S_HALTED} state_t;

    // Parameter sanity: the 28-bit jump field must fit, and the stack
    // pointer arithmetic relies on a power-of-two depth.
    if (ADDR_W < 28) begin : g_bad_addr_w
        $error("pc_sequencer: ADDR_W must be at least 28");
    end
    if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_sequencer: RAS_DEPTH must be a power of two in 2..16");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] link_q, link_d;
    logic [ADDR_W-1:0] br_off, jump_tgt, jreg_tgt;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ras_top_q points at the next free slot; entries wrap so a push when
    // full silently overwrites the oldest link.
    logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_mem_d [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_top_q, ras_top_d, ras_rd_idx;
    logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
    logic              ras_push, ras_pop;
    logic              ras_miss_q, ras_miss_d;
`endif

    // Target address candidates; all arithmetic wraps modulo 2^ADDR_W.
    always_comb begin
        pc_plus4  = pc_q + ADDR_W'(4);
        br_off    = {{(ADDR_W-18){immd16[15]}}, immd16, 2'b00};
        jump_tgt  = pc_q;
        jump_tgt[27:0] = {immd26, 2'b00};
        jreg_tgt  = reg_target;
        jreg_tgt[1:0]  = 2'b00;
    end

    // Next-state, next-PC and link selection; stall freezes everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        link_d  = link_q;
`ifdef PC_RAS_EN
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        ras_miss_d = 1'b0;
`endif
        if (!stall) begin
            case (state_q)
                S_RUN: begin
                    case (sel)
                        SEL_BRANCH: pc_d = pc_plus4 + br_off;
                        SEL_JUMP:   pc_d = jump_tgt;
                        SEL_HALT:   state_d = S_HALTED;
                        SEL_JREG:   pc_d = jreg_tgt;
                        SEL_CALL: begin
                            pc_d   = jump_tgt;
                            link_d = pc_plus4;
`ifdef PC_RAS_EN
                            ras_push = 1'b1;
`endif
                        end
                        SEL_RET: begin
`ifdef PC_RAS_EN
                            if (ras_cnt_q != '0) begin
                                pc_d    = ras_mem_q[ras_rd_idx];
                                ras_pop = 1'b1;
                            end else begin
                                pc_d       = jreg_tgt;
                                ras_miss_d = 1'b1;
                            end
`else
                            pc_d = jreg_tgt;
`endif
                        end
                        default:    pc_d = pc_plus4;  // NEXT and reserved 7
                    endcase
                end
                S_HALTED: begin
                    if (resume) begin
                        pc_d    = pc_plus4;
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    // PC, link and FSM registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= S_RUN;
            pc_q    <= RESET_VECTOR;
            link_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            link_q  <= link_d;
        end
    end

`ifdef PC_RAS_EN
    // Stack pointer/count update; count saturates at RAS_DEPTH.
    always_comb begin
        ras_rd_idx = ras_top_q - PTR_W'(1);
        ras_mem_d  = ras_mem_q;
        ras_top_d  = ras_top_q;
        ras_cnt_d  = ras_cnt_q;
        if (ras_push) begin
            ras_mem_d[ras_top_q] = pc_plus4;
            ras_top_d = ras_top_q + PTR_W'(1);
            if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + CNT_W'(1);
        end else if (ras_pop) begin
            ras_top_d = ras_rd_idx;
            ras_cnt_d = ras_cnt_q - CNT_W'(1);
        end
    end

    // Stack storage and miss pulse; reset empties the stack with no miss.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem_q[i] <= '0;
            ras_top_q  <= '0;
            ras_cnt_q  <= '0;
            ras_miss_q <= 1'b0;
        end else begin
            ras_mem_q  <= ras_mem_d;
            ras_top_q  <= ras_top_d;
            ras_cnt_q  <= ras_cnt_d;
            ras_miss_q <= ras_miss_d;
        end
    end

    assign ras_miss = ras_miss_q;
`else
    assign ras_miss = 1'b0;
`endif

    assign pc        = pc_q;
    assign link_addr = link_q;
    assign halted    = (state_q == S_HALTED);

endmodule
